// File: rtl/lfsr_server.sv
// lfsr_server: shared pseudo-random number server.
// One N-bit Fibonacci LFSR is handed out to R requesters via round-robin
// request/grant; each service advances the LFSR STEPS times before the value
// is published on data with a one-cycle data_valid pulse.
// Optional feature macro: LFSR_SERVER_LOCKUP_EN (all-zero lockup protection).
module lfsr_server #(
  parameter int             N         = 8,
  parameter logic [N-1:0]   TAPS      = N'(8'hB8),
  parameter int             STEPS     = 4,
  parameter int             R         = 4,
  parameter logic [N-1:0]   SEED_INIT = N'(1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [R-1:0] req,
  output logic [R-1:0] gnt,
  output logic         data_valid,
  output logic [N-1:0] data,
  input  logic         seed_load,
  input  logic [N-1:0] seed_data,
  output logic         busy
);

  localparam int CW = $clog2(STEPS + 1);
  localparam int PW = $clog2(R);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    lfsr_q, lfsr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [R-1:0]    gnt_q, gnt_d;
  logic            dv_q, dv_d;
  logic [N-1:0]    data_q, data_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [CW-1:0]   cnt_inc;
  logic            last_step;

  // One Fibonacci step; an all-zero state is pulled back to 1 when protected.
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] v);
`ifdef LFSR_SERVER_LOCKUP_EN
    if (v == '0) return N'(1);
`endif
    return {v[N-2:0], ^(v & TAPS)};
  endfunction

  // Seed conditioning; an all-zero seed would lock the LFSR forever.
  function automatic logic [N-1:0] seed_fix(input logic [N-1:0] s);
`ifdef LFSR_SERVER_LOCKUP_EN
    if (s == '0) return N'(1);
`endif
    return s;
  endfunction

  assign cnt_inc   = cnt_q + CW'(1);
  assign last_step = (cnt_inc == CW'(STEPS));

  // Round-robin winner: first active request at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < R; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % R]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % R);
      end
    end
  end

  // State register plus all registered outputs and datapath state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_INIT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; seed_load in IDLE takes priority over a grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!seed_load && win_found) state_d = S_STEP;
      S_STEP:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values, registered one cycle later.
  always_comb begin
    lfsr_d = lfsr_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    gnt_d  = gnt_q;
    dv_d   = 1'b0;
    data_d = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        gnt_d = '0;
        if (seed_load) begin
          lfsr_d = seed_fix(seed_data);
        end else if (win_found) begin
          gnt_d = {{(R-1){1'b0}}, 1'b1} << win_idx;
          ptr_d = (win_idx == PW'(R - 1)) ? '0 : win_idx + PW'(1);
        end
      end
      S_STEP: begin
        lfsr_d = lfsr_next(lfsr_q);
        cnt_d  = cnt_inc;
        if (last_step) begin
          data_d = lfsr_d;
          dv_d   = 1'b1;
        end
      end
      S_DONE: begin
        gnt_d = '0;
        cnt_d = '0;
      end
      default: begin
        gnt_d = '0;
        cnt_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign gnt        = gnt_q;
  assign data_valid = dv_q;
  assign data       = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lfsr_server.sv
// Directed bench for lfsr_server: default instance (STEPS=4) and a STEPS=1
// instance for the full-period run. Expected values are hand computed for
// TAPS=8'hB8 starting from seed 8'h01.
module tb_lfsr_server;

  localparam int N = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, seed_load_a, dv_a, busy_a;
  logic [R-1:0] req_a, gnt_a;
  logic [N-1:0] seed_data_a, data_a;

  logic         rst_b, seed_load_b, dv_b, busy_b;
  logic [R-1:0] req_b, gnt_b;
  logic [N-1:0] seed_data_b, data_b;

  lfsr_server u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .req        (req_a),
    .gnt        (gnt_a),
    .data_valid (dv_a),
    .data       (data_a),
    .seed_load  (seed_load_a),
    .seed_data  (seed_data_a),
    .busy       (busy_a)
  );

  lfsr_server #(.STEPS(1)) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .req        (req_b),
    .gnt        (gnt_b),
    .data_valid (dv_b),
    .data       (data_b),
    .seed_load  (seed_load_b),
    .seed_data  (seed_data_b),
    .busy       (busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves DUT A in cycle 0: IDLE, sampling req at the next edge.
  task automatic reset_a(input logic [R-1:0] r);
    rst_a       = 1'b1;
    seed_load_a = 1'b0;
    seed_data_a = '0;
    req_a       = r;
    tick();
    tick();
    rst_a = 1'b0;
  endtask

  logic [R-1:0] exp_g [5];
  logic [N-1:0] exp_b [4];
  int           dv_count;
  int           k;

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b = '{8'h02, 8'h04, 8'h08, 8'h11};
    rst_b = 1'b1; seed_load_b = 1'b0; seed_data_b = '0; req_b = '0;
    rst_a = 1'b1; seed_load_a = 1'b0; seed_data_a = '0; req_a = '0;

    // Test 1: single requester, two back-to-back services.
    reset_a(4'b0001);
    check_eq("rst gnt",  gnt_a,  4'b0000);
    check_eq("rst busy", busy_a, 1'b0);
    check_eq("rst dv",   dv_a,   1'b0);
    check_eq("rst data", data_a, 8'h00);
    tick();
    check_eq("t1 c1 gnt",  gnt_a,  4'b0001);
    check_eq("t1 c1 busy", busy_a, 1'b1);
    tick(); tick(); tick();
    check_eq("t1 c4 dv", dv_a, 1'b0);
    tick();
    check_eq("t1 c5 dv",   dv_a,   1'b1);
    check_eq("t1 c5 data", data_a, 8'h11);
    check_eq("t1 c5 gnt",  gnt_a,  4'b0001);
    tick();
    check_eq("t1 c6 gnt",  gnt_a,  4'b0000);
    check_eq("t1 c6 dv",   dv_a,   1'b0);
    check_eq("t1 c6 busy", busy_a, 1'b0);
    check_eq("t1 c6 data", data_a, 8'h11);
    tick();
    check_eq("t1 c7 gnt", gnt_a, 4'b0001);
    tick(); tick(); tick(); tick();
    check_eq("t1 c11 dv",   dv_a,   1'b1);
    check_eq("t1 c11 data", data_a, 8'h1C);
    req_a = '0;

    // Test 3: seed_load beats req in IDLE; seed during STEP is ignored.
    tick();
    check_eq("t3 idle gnt", gnt_a, 4'b0000);
    seed_load_a = 1'b1; seed_data_a = 8'h01; req_a = 4'b0100;
    tick();
    check_eq("t3 seed gnt",  gnt_a,  4'b0000);
    check_eq("t3 seed busy", busy_a, 1'b0);
    seed_load_a = 1'b0;
    tick();
    check_eq("t3 grant", gnt_a, 4'b0100);
    seed_load_a = 1'b1; seed_data_a = 8'hA5; req_a = '0;
    tick();
    seed_load_a = 1'b0;
    tick(); tick(); tick();
    check_eq("t3 dv",   dv_a,   1'b1);
    check_eq("t3 data", data_a, 8'h11);
    tick();
    check_eq("t3 gnt off", gnt_a, 4'b0000);
    tick();
    check_eq("t3 idle busy", busy_a, 1'b0);
    check_eq("t3 no regrant", gnt_a, 4'b0000);

    // Test 2: all requesters held; round-robin order, 6 cycles per grant.
    reset_a(4'b1111);
    dv_count = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (dv_a) dv_count++;
      if ((c - 1) % 6 == 0) check_eq("t2 gnt", gnt_a, exp_g[(c - 1) / 6]);
      if (c >= 5 && (c - 5) % 6 == 0) check_eq("t2 dv", dv_a, 1'b1);
    end
    check_eq("t2 dv count", dv_count, 5);

    // Test 4: reset in the 2nd STEP cycle kills the service.
    reset_a(4'b0001);
    tick();
    check_eq("t4 gnt", gnt_a, 4'b0001);
    tick();
    rst_a = 1'b1;
    #1;
    check_eq("t4 rst gnt",  gnt_a,  4'b0000);
    check_eq("t4 rst busy", busy_a, 1'b0);
    check_eq("t4 rst dv",   dv_a,   1'b0);
    check_eq("t4 rst data", data_a, 8'h00);
    tick();
    rst_a = 1'b0;
    check_eq("t4 rel gnt", gnt_a, 4'b0000);
    tick();
    check_eq("t4 regrant", gnt_a, 4'b0001);
    tick(); tick(); tick();
    check_eq("t4 c4 dv",   dv_a,   1'b0);
    check_eq("t4 c4 data", data_a, 8'h00);
    tick();
    check_eq("t4 c5 dv",   dv_a,   1'b1);
    check_eq("t4 c5 data", data_a, 8'h11);
    req_a = '0;

    // Test 6: all-zero seed.
    reset_a(4'b0000);
    seed_load_a = 1'b1; seed_data_a = 8'h00;
    tick();
    seed_load_a = 1'b0; req_a = 4'b0001;
    tick();
    check_eq("t6 gnt", gnt_a, 4'b0001);
    tick(); tick(); tick(); tick();
    check_eq("t6 dv", dv_a, 1'b1);
`ifdef LFSR_SERVER_LOCKUP_EN
    check_eq("t6 data", data_a, 8'h11);
`else
    check_eq("t6 data", data_a, 8'h00);
`endif
    req_a = '0;

    // Test 5: STEPS=1 instance, 255 services cover the full period.
    tick();
    req_b = 4'b0001;
    tick();
    rst_b = 1'b0;
    k = 0;
    for (int c = 1; c <= 900 && k < 255; c++) begin
      tick();
      if (dv_b) begin
        k++;
        if (k <= 4) check_eq("t5 data", data_b, exp_b[k - 1]);
        if (k == 1) check_eq("t5 first cyc", c, 2);
        if (k == 255) begin
          check_eq("t5 last data", data_b, 8'h01);
          check_eq("t5 last cyc",  c, 764);
        end
      end
    end
    check_eq("t5 services", k, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_server.md
# lfsr_server

Shared pseudo-random number server. It owns one N-bit Fibonacci LFSR and hands fresh values to up to R requesters through a round-robin request/grant handshake. Each service advances the LFSR STEPS times, so consecutive consumers receive decorrelated values. It sits between the counter/LFSR datapath and any blocks that need random stimulus, such as scramblers, test-pattern generators and backoff timers.

## Interface
- N, 8: LFSR width, ≥3.
- TAPS, 8'hB8: feedback mask. Default is maximal-length for N=8 (period 255).
- STEPS, 4: LFSR advances per service, ≥1.
- R, 4: number of requesters, ≥2.
- SEED_INIT, 1: LFSR value after reset.
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  R  per-requester request level.
- gnt  out  R  one-hot grant; held for the whole service.
- data_valid  out  1  one-cycle pulse; data is the result for the granted requester.
- data  out  N  last served LFSR value; holds between services.
- seed_load  in  1  load seed_data into the LFSR.
- seed_data  in  N  seed value.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- LFSR step: fb = ^(lfsr & TAPS); lfsr ← {lfsr[N-2:0], fb}.
- FSM states and transitions:
  - IDLE: if seed_load, load seed and stay in IDLE. Else if req≠0, grant the round-robin winner and go to STEP.
  - STEP: step the LFSR once per cycle; cnt counts 1..STEPS. After the STEPS-th step, go to DONE.
  - DONE: data ← lfsr, data_valid=1, gnt held, then go to IDLE.
- Round-robin:
  - Search starts at ptr and wraps from R-1 to 0.
  - On grant of index i, ptr ← (i+1) mod R.
  - A single requester can be granted back-to-back.
- seed_load:
  - Honoured only in IDLE, where it beats req in the same cycle and no grant is issued.
  - Ignored in STEP and DONE; it is not queued.
- Request drop: if req[i] drops during a service, the service still completes and data_valid still pulses. The requester must ignore it.
- gnt deasserts on the IDLE cycle that follows DONE. A held req is re-arbitrated in that IDLE cycle.
- Reset (any time, including mid-service):
  - state=IDLE, lfsr=SEED_INIT, ptr=0.
  - gnt=0, data_valid=0, data=0, busy=0, cnt=0.
  - The interrupted service is lost with no data_valid.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: gnt and busy rise; first step at the end of cycle 1.
- Cycles 1..STEPS: STEP.
- Cycle STEPS+1: DONE, data_valid=1, data updated.
- Cycle STEPS+2: IDLE, gnt=0. The earliest next grant is visible in cycle STEPS+3.
- Service occupancy is STEPS+2 cycles per grant, including the IDLE arbitration cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- LFSR_SERVER_LOCKUP_EN: all-zero lockup protection.
  - Defined: a seed_load of all-zero loads 1 instead. If the LFSR is ever observed all-zero in STEP, it is forced to 1 for that step.
  - Undefined: an all-zero seed is loaded as-is. The LFSR then stays zero, and every service returns data=0.

## Test plan
1. Reset with defaults, req=4'b0001 held.
   - Expected: gnt=0001 in cycle 1, data_valid in cycle 5 with data=8'h11.
   - Second service: data=8'h1C, data_valid in cycle 11.
2. req=4'b1111 held continuously from reset.
   - Expected: grants in order 0001, 0010, 0100, 1000, 0001.
   - Exactly one data_valid per grant, 6 cycles apart.
3. In IDLE, seed_load=1 with seed_data=8'h01 together with req=4'b0100.
   - Expected: no grant that cycle; the LFSR is reseeded; the grant follows in the next cycle.
   - With seed_data=8'hA5 applied during STEP, the seed is ignored and the data matches the unseeded sequence.
4. Assert reset for one cycle at the 2nd STEP cycle.
   - Expected: immediately gnt=0, busy=0, data_valid never pulses, data=0, lfsr=01.
   - A held req is then granted in the cycle after reset is released.
5. STEPS=1, seed 8'h01, 255 back-to-back services by req[0].
   - Expected: data runs 02, 04, 08, 11, …, and service 255 returns 8'h01 (full period).
6. seed_data=8'h00 loaded, then one request.
   - With LFSR_SERVER_LOCKUP_EN: data=8'h11 (effective seed 01).
   - Without it: data=8'h00.
